// File: rtl/cpu_control.sv
// Multi-cycle control unit: sequences fetch / IR load / up to three execute steps
// and drives the datapath bus select, register enables and memory write strobe.
module cpu_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        N,
  input  logic        Z,
  output logic [2:0]  sel,
  output logic        addsub,
  output logic        pc_incr,
  output logic        h,
  output logic [14:0] r_enable,
  output logic        o_mem_wr
);

  localparam logic [2:0] SEL_RX    = 3'd0;
  localparam logic [2:0] SEL_RY    = 3'd1;
  localparam logic [2:0] SEL_PC    = 3'd2;
  localparam logic [2:0] SEL_S     = 3'd3;
  localparam logic [2:0] SEL_IMM8  = 3'd4;
  localparam logic [2:0] SEL_IMM11 = 3'd5;
  localparam logic [2:0] SEL_RDATA = 3'd6;

  localparam int EN_A      = 8;
  localparam int EN_S      = 9;
  localparam int EN_FLAGS  = 10;
  localparam int EN_IR     = 11;
  localparam int EN_ADDR   = 12;
  localparam int EN_WRDATA = 13;
  localparam int EN_PC     = 14;

  localparam logic [4:0] OP_MV   = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b00100;
  localparam logic [4:0] OP_ST   = 5'b00101;
  localparam logic [4:0] OP_MVI  = 5'b10000;
  localparam logic [4:0] OP_MVHI = 5'b10110;
  localparam logic [4:0] OP_CALL = 5'b11100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_LOADIR = 3'd2,
    S_EX1    = 3'd3,
    S_EX2    = 3'd4,
    S_EX3    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [4:0]  opcode_s;
  logic [2:0]  rx_s;
  logic [14:0] gpr_en_s;
  logic        is_alu_s;
  logic        is_cmp_s;
  logic        is_jr_s;
  logic        is_j_s;
  logic        is_call_s;
  logic        cond_s;
  logic [2:0]  sel_s;
  logic        addsub_s;
  logic        pc_incr_s;
  logic        h_s;
  logic [14:0] ren_s;
  logic        mem_wr_s;

  function automatic logic [14:0] gpr_onehot(input logic [2:0] idx);
    return 15'd1 << idx;
  endfunction

  assign opcode_s  = instruction[4:0];
  assign rx_s      = instruction[7:5];
  assign gpr_en_s  = gpr_onehot(rx_s);
  // x00xx with a nonzero low pair covers add/sub/cmp and their immediate forms
  assign is_alu_s  = (opcode_s[3:2] == 2'b00) && (opcode_s[1:0] != 2'b00);
  assign is_cmp_s  = is_alu_s && (opcode_s[1:0] == 2'b11);
  assign is_jr_s   = (opcode_s[4:2] == 3'b010) && (opcode_s[1:0] != 2'b11);
  assign is_j_s    = (opcode_s[4:2] == 3'b110) && (opcode_s[1:0] != 2'b11);
  assign is_call_s = (opcode_s == OP_CALL);

  // Branch condition selected by the low opcode bits: always / Z / N.
  always_comb begin
    cond_s = 1'b0;
    case (opcode_s[1:0])
      2'b00:   cond_s = 1'b1;
      2'b01:   cond_s = Z;
      2'b10:   cond_s = N;
      default: cond_s = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction and returns to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode for the current step.
  always_comb begin
    next_state_s = state_r;
    sel_s        = 3'd0;
    addsub_s     = 1'b0;
    pc_incr_s    = 1'b0;
    h_s          = 1'b0;
    ren_s        = 15'd0;
    mem_wr_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        sel_s            = SEL_PC;
        ren_s[EN_ADDR]   = 1'b1;
        pc_incr_s        = 1'b1;
        next_state_s     = S_FWAIT;
      end
      S_FWAIT: begin
        next_state_s = S_LOADIR;
      end
      S_LOADIR: begin
        ren_s[EN_IR] = 1'b1;
        next_state_s = S_EX1;
      end
      S_EX1: begin
        next_state_s = S_FETCH;
        if (opcode_s == OP_MV) begin
          sel_s = SEL_RY;
          ren_s = gpr_en_s;
        end else if ((opcode_s == OP_MVI) || (opcode_s == OP_MVHI)) begin
          sel_s = SEL_IMM8;
          ren_s = gpr_en_s;
          h_s   = (opcode_s == OP_MVHI);
        end else if (is_alu_s) begin
          sel_s        = SEL_RX;
          ren_s[EN_A]  = 1'b1;
          next_state_s = S_EX2;
        end else if ((opcode_s == OP_LD) || (opcode_s == OP_ST)) begin
          sel_s          = SEL_RY;
          ren_s[EN_ADDR] = 1'b1;
          next_state_s   = S_EX2;
        end else if (is_jr_s) begin
          if (cond_s) begin
            sel_s        = SEL_RX;
            ren_s[EN_PC] = 1'b1;
          end else begin
            ren_s = 15'd0;
          end
        end else if (is_j_s || is_call_s) begin
          // PC already points past this instruction: it becomes both the
          // offset base in A and, for call, the return address in R7.
          if (is_call_s || cond_s) begin
            sel_s        = SEL_PC;
            ren_s[EN_A]  = 1'b1;
            ren_s[7]     = is_call_s;
            next_state_s = S_EX2;
          end else begin
            ren_s = 15'd0;
          end
        end else begin
          ren_s = 15'd0;
        end
      end
      S_EX2: begin
        next_state_s = S_EX3;
        if (is_alu_s) begin
          sel_s           = opcode_s[4] ? SEL_IMM8 : SEL_RY;
          addsub_s        = opcode_s[1];
          ren_s[EN_S]     = 1'b1;
          ren_s[EN_FLAGS] = 1'b1;
          next_state_s    = is_cmp_s ? S_FETCH : S_EX3;
        end else if (opcode_s == OP_LD) begin
          ren_s = 15'd0;
        end else if (opcode_s == OP_ST) begin
          sel_s            = SEL_RX;
          ren_s[EN_WRDATA] = 1'b1;
        end else if (is_j_s || is_call_s) begin
          sel_s       = SEL_IMM11;
          ren_s[EN_S] = 1'b1;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_EX3: begin
        next_state_s = S_FETCH;
        if (is_alu_s) begin
          sel_s = SEL_S;
          ren_s = gpr_en_s;
        end else if (opcode_s == OP_LD) begin
          sel_s = SEL_RDATA;
          ren_s = gpr_en_s;
        end else if (opcode_s == OP_ST) begin
          mem_wr_s = 1'b1;
        end else if (is_j_s || is_call_s) begin
          sel_s        = SEL_S;
          ren_s[EN_PC] = 1'b1;
        end else begin
          ren_s = 15'd0;
        end
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, even though the state already reads FETCH.
  assign sel      = reset ? sel_s     : 3'd0;
  assign addsub   = reset ? addsub_s  : 1'b0;
  assign pc_incr  = reset ? pc_incr_s : 1'b0;
  assign h        = reset ? h_s       : 1'b0;
  assign r_enable = reset ? ren_s     : 15'd0;
  assign o_mem_wr = reset ? mem_wr_s  : 1'b0;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: a small datapath model driven by the control
// outputs executes a hand-traced program and its results are checked.
module tb_cpu_control;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        n_m;
  logic        z_m;
  logic [2:0]  sel;
  logic        addsub;
  logic        pc_incr;
  logic        h;
  logic [14:0] r_enable;
  logic        o_mem_wr;

  int n_tests;
  int n_fail;

  cpu_control dut (
    .clk(clk), .reset(reset), .instruction(instruction), .N(n_m), .Z(z_m),
    .sel(sel), .addsub(addsub), .pc_incr(pc_incr), .h(h),
    .r_enable(r_enable), .o_mem_wr(o_mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] out_w;
  assign out_w = {sel, addsub, pc_incr, h, r_enable, o_mem_wr};

  function automatic logic [21:0] cw(input logic [2:0] s, input logic as, input logic pci,
                                     input logic hh, input logic [14:0] en, input logic mw);
    return {s, as, pci, hh, en, mw};
  endfunction

  // Datapath model
  logic        dp_clr;
  logic [15:0] rf [8];
  logic [15:0] a_m, s_m, pc_m, addr_m, wd_m, mem_addr_m, mem_data_m, fetch_addr_m;
  logic [15:0] bus_m, alu_m, rdata_m;
  int          mem_wr_cnt, flag_loads, gpr_cnt, viol_cnt;

  assign rdata_m = (addr_m == mem_addr_m) ? mem_data_m : 16'h0000;
  assign alu_m   = addsub ? (a_m - bus_m) : (a_m + bus_m);

  always_comb begin
    bus_m = 16'h0000;
    case (sel)
      3'd0: bus_m = rf[instruction[7:5]];
      3'd1: bus_m = rf[instruction[10:8]];
      3'd2: bus_m = pc_m;
      3'd3: bus_m = s_m;
      3'd4: bus_m = {8'h00, instruction[15:8]};
      3'd5: bus_m = {{4{instruction[15]}}, instruction[15:5], 1'b0};
      3'd6: bus_m = rdata_m;
      default: bus_m = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      a_m <= 16'h0000; s_m <= 16'h0000; pc_m <= 16'h0000; addr_m <= 16'h0000;
      wd_m <= 16'h0000; mem_addr_m <= 16'hFFFF; mem_data_m <= 16'h0000;
      fetch_addr_m <= 16'hFFFF; n_m <= 1'b0; z_m <= 1'b0;
      mem_wr_cnt <= 0; flag_loads <= 0;
    end else if (reset) begin
      for (int i = 0; i < 8; i++) begin
        if (r_enable[i]) rf[i] <= h ? {bus_m[7:0], rf[i][7:0]} : bus_m;
      end
      if (r_enable[8])  a_m <= bus_m;
      if (r_enable[9])  s_m <= alu_m;
      if (r_enable[10]) begin
        n_m <= alu_m[15];
        z_m <= (alu_m == 16'h0000);
        flag_loads <= flag_loads + 1;
      end
      if (r_enable[12]) addr_m <= bus_m;
      if (r_enable[12] && pc_incr) fetch_addr_m <= bus_m;
      if (r_enable[13]) wd_m <= bus_m;
      if (r_enable[14]) pc_m <= bus_m;
      else if (pc_incr) pc_m <= pc_m + 16'd2;
      if (o_mem_wr) begin
        mem_addr_m <= addr_m;
        mem_data_m <= wd_m;
        mem_wr_cnt <= mem_wr_cnt + 1;
      end
    end
  end

  // Per-cycle invariant monitor
  always @(negedge clk) begin
    if (dp_clr) begin
      viol_cnt <= 0;
      gpr_cnt  <= 0;
    end else if (reset) begin
      if ((pc_incr && r_enable[14]) || (h && instruction[4:0] != 5'b10110) ||
          ($countones(r_enable[7:0]) > 1))
        viol_cnt <= viol_cnt + 1;
      if (|r_enable[7:0]) gpr_cnt <= gpr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered in FETCH just after a negedge; returns at the negedge of the next FETCH.
  task automatic exec(input string tag, input logic [15:0] instr, input int exp_cyc);
    int cyc;
    instruction = instr;
    cyc = 1;
    while (cyc <= 16) begin
      @(negedge clk);
      if (pc_incr) break;
      cyc++;
    end
    check_eq({tag, "_cycles"}, cyc, exp_cyc);
  endtask

  task automatic run_words(input string tag, input logic [15:0] instr, input logic [21:0] w [6]);
    instruction = instr;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check_eq($sformatf("%s_c%0d", tag, i), out_w, w[i]);
    end
    @(negedge clk);
    check_eq({tag, "_latency"}, pc_incr, 1'b1);
  endtask

  logic [21:0] fetch_w;
  logic [21:0] st_w [6];
  int          mark;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fetch_w = cw(3'd2, 1'b0, 1'b1, 1'b0, 15'h1000, 1'b0);
    st_w[0] = fetch_w;
    st_w[1] = 22'd0;
    st_w[2] = cw(3'd0, 1'b0, 1'b0, 1'b0, 15'h0800, 1'b0);
    st_w[3] = cw(3'd1, 1'b0, 1'b0, 1'b0, 15'h1000, 1'b0);
    st_w[4] = cw(3'd0, 1'b0, 1'b0, 1'b0, 15'h2000, 1'b0);
    st_w[5] = cw(3'd0, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b1);
    instruction = 16'h0000;
    dp_clr = 1'b1;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", out_w, 22'd0);
    dp_clr = 1'b0;
    reset  = 1'b1;
    #1 check_eq("release_fetch", out_w, fetch_w);

    exec("mvi_r1", 16'h0530, 4);
    mark = flag_loads;
    exec("add_r1", 16'h0121, 6);
    check_eq("add_r1_val", rf[1], 16'h000A);
    check_eq("add_flags", {n_m, z_m}, 2'b00);
    check_eq("add_flag_loads", flag_loads - mark, 1);

    exec("mvi_r2", 16'h0350, 4);
    mark = gpr_cnt;
    exec("cmpi_eq", 16'h0353, 5);
    check_eq("cmpi_flags", {n_m, z_m}, 2'b01);
    check_eq("cmpi_no_gpr_en", gpr_cnt - mark, 0);

    exec("mvi_r3", 16'hEF70, 4);
    exec("mvhi_r3", 16'hBE76, 4);
    check_eq("r3_val", rf[3], 16'hBEEF);
    exec("mvi_r4", 16'h4090, 4);
    exec("st", 16'h0465, 6);
    check_eq("st_wr_cnt", mem_wr_cnt, 1);
    check_eq("st_addr", mem_addr_m, 16'h0040);
    check_eq("st_data", mem_data_m, 16'hBEEF);
    exec("ld", 16'h04A4, 6);
    check_eq("ld_r5", rf[5], 16'hBEEF);

    exec("jz_taken", 16'h0079, 6);
    check_eq("jz_taken_pc", pc_m, 16'h001A);
    exec("mvi_r6", 16'h10D0, 4);
    exec("jr", 16'h00C8, 4);
    check_eq("jr_pc", pc_m, 16'h0010);
    mark = flag_loads;
    exec("call", 16'h041C, 6);
    check_eq("call_r7", rf[7], 16'h0012);
    check_eq("call_pc", pc_m, 16'h0052);
    check_eq("call_flags", {n_m, z_m}, 2'b01);
    check_eq("call_flag_loads", flag_loads - mark, 0);

    exec("cmpi_lt", 16'h0553, 5);
    check_eq("cmpi_lt_flags", {n_m, z_m}, 2'b10);
    exec("jz_not", 16'h0079, 4);
    check_eq("jz_not_pc", pc_m, 16'h0056);
    exec("jnr", 16'h00CA, 4);
    check_eq("jnr_pc", pc_m, 16'h0010);
    exec("jzr_not", 16'h00C9, 4);
    check_eq("jzr_not_pc", pc_m, 16'h0012);
    exec("sub", 16'h0222, 6);
    check_eq("sub_r1", rf[1], 16'h0007);
    check_eq("sub_flags", {n_m, z_m}, 2'b00);
    exec("cmp", 16'h0243, 5);
    check_eq("cmp_flags", {n_m, z_m}, 2'b01);
    exec("nop", 16'h000B, 4);
    check_eq("nop_pc", pc_m, 16'h0018);

    run_words("st_words", 16'h0465, st_w);
    check_eq("st2_wr_cnt", mem_wr_cnt, 2);

    // st aborted by reset in EX2
    instruction = 16'h0465;
    repeat (4) @(negedge clk);
    check_eq("abort_ex2_word", out_w, st_w[4]);
    #2 reset = 1'b0;
    #1 check_eq("abort_async_zero", out_w, 22'd0);
    repeat (2) @(negedge clk);
    check_eq("abort_held_zero", out_w, 22'd0);
    check_eq("abort_no_write", mem_wr_cnt, 2);
    reset = 1'b1;
    #1 check_eq("abort_release_fetch", out_w, fetch_w);
    exec("post_abort_nop", 16'h000B, 4);
    check_eq("post_abort_fetch_addr", fetch_addr_m, 16'h001C);
    check_eq("post_abort_wr_cnt", mem_wr_cnt, 2);

    check_eq("invariants", viol_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
